adder_share_arb: RTL and testbench



---
 rtl/adder_share_arb_pkg.sv | 22 ++
 rtl/adder_share_arb_if.sv | 37 +++
 rtl/Adder_gear.sv | 54 +++++
 rtl/adder_share_arb_rr_arbiter.sv | 39 +++
 rtl/adder_share_arb.sv | 118 +++++++++++
 tb/tb_adder_share_arb.sv | 193 +++++++++++++++++++
 6 files changed

// File: rtl/adder_share_arb_pkg.sv
// Shared definitions for the adder-sharing arbiter slice.
//   max_i  : larger of two integers (result width of the shared adder)
//   id_w   : requester-index width, never narrower than one bit
//   occ_e  : pipeline occupancy; the encoding is {s1_valid, s2_valid}
package adder_share_pkg;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int id_w(input int n);
    return (n < 3) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    S2_ONLY = 2'b01,
    S1_ONLY = 2'b10,
    FULL    = 2'b11
  } occ_e;

endpackage

// File: rtl/adder_share_arb_if.sv
// Requester and result bundle of adder_share_arb.
//   req_valid/req_ready/req_a/req_b/req_carry : per-requester issue side
//   res_valid/res_ready/res_data/res_id       : single result port
//   busy                                      : a pipeline stage is occupied
// The slave modport is the arbiter; the master modport is the client side.
interface adder_share_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH_A = 4,
  parameter int WIDTH_B = 8
);
  import adder_share_pkg::*;

  localparam int BITS = max_i(WIDTH_A, WIDTH_B);
  localparam int ID_W = id_w(NUM_REQ);

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*WIDTH_A-1:0] req_a;
  logic [NUM_REQ*WIDTH_B-1:0] req_b;
  logic [NUM_REQ-1:0]         req_carry;
  logic                       res_valid;
  logic                       res_ready;
  logic [BITS-1:0]            res_data;
  logic [ID_W-1:0]            res_id;
  logic                       busy;

  modport master (
    output req_valid, req_a, req_b, req_carry, res_ready,
    input  req_ready, res_valid, res_data, res_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_carry, res_ready,
    output req_ready, res_valid, res_data, res_id, busy
  );

endinterface

// File: rtl/Adder_gear.sv
// Configurable-accuracy (GeAr-style) adder.
//   A, B : operands, zero-padded to BITS = max(WIDTH_A, WIDTH_B)
//   Cin  : carry into bit 0
//   OUT  : BITS-bit approximate sum, carry-out discarded
// The sum is built from segments of R+P bits. The lowest segment uses Cin;
// every higher segment takes a carry predicted only from the P bits just
// below it (added with zero carry-in), so long carry chains are cut.
// R+P == 0 degenerates to an exact adder.
module Adder_gear
  import adder_share_pkg::*;
#(
  parameter int R       = 0,
  parameter int P       = 2,
  parameter int WIDTH_A = 4,
  parameter int WIDTH_B = 8
) (
  input  logic [WIDTH_A-1:0]                 A,
  input  logic [WIDTH_B-1:0]                 B,
  input  logic                               Cin,
  output logic [max_i(WIDTH_A,WIDTH_B)-1:0]  OUT
);

  localparam int          BITS = max_i(WIDTH_A, WIDTH_B);
  localparam int unsigned NB   = BITS;
  localparam int unsigned PW   = P;
  localparam int unsigned SEG  = ((R + P) == 0) ? NB : (R + P);

  logic [BITS-1:0] a;
  logic [BITS-1:0] b;
  logic [BITS-1:0] s;
  logic            c;
  logic            pc;

  always_comb begin
    a  = BITS'(A);
    b  = BITS'(B);
    s  = '0;
    c  = Cin;
    pc = 1'b0;
    for (int unsigned i = 0; i < NB; i++) begin
      if ((i != 0) && ((i % SEG) == 0)) begin
        pc = 1'b0;
        for (int unsigned j = i - PW; j < i; j++) begin
          pc = (a[j] & b[j]) | (pc & (a[j] ^ b[j]));
        end
        c = pc;
      end
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    OUT = s;
  end

endmodule

// File: rtl/adder_share_arb_rr_arbiter.sv
// Round-robin arbiter.
//   req : request vector
//   ptr : highest-priority index (must be < N)
//   en  : grant enable; idx is still computed when low
//   gnt : one-hot grant (zero when en is low or nothing requests)
//   idx : index of the first requester at or after ptr, cyclically
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  localparam int unsigned NU = N;

  logic        found;
  int unsigned j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned off = 0; off < NU; off++) begin
      j = 32'(ptr) + off;
      if (j >= NU) j = j - NU;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
    if (en && found) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/adder_share_arb.sv
// Shares one Adder_gear among NUM_REQ requesters.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : adder_share_arb_if slave (requests in, tagged results out)
// Pipeline: S1 holds the granted operands and feeds the adder; S2 holds the
// sum and requester id and drives the result port. A full pipeline keeps
// streaming when res_ready is high (pop, S1->S2 and new grant together).
module adder_share_arb
  import adder_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH_A = 4,
  parameter int WIDTH_B = 8,
  parameter int R       = 0,
  parameter int P       = 2
) (
  input logic              clk,
  input logic              rst,
  adder_share_arb_if.slave bus
);

  localparam int BITS = max_i(WIDTH_A, WIDTH_B);
  localparam int ID_W = id_w(NUM_REQ);
  localparam logic [ID_W-1:0] LAST = ID_W'(NUM_REQ - 1);

  occ_e occ_q, occ_d;

  logic               s1_valid, s2_valid;
  logic               s1_next, s2_next;
  logic               s2_adv, s1_acc, hs;
  logic [WIDTH_A-1:0] s1_a;
  logic [WIDTH_B-1:0] s1_b;
  logic               s1_carry;
  logic [ID_W-1:0]    s1_id;
  logic [BITS-1:0]    s2_data;
  logic [ID_W-1:0]    s2_id;
  logic [ID_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    win;
  logic [BITS-1:0]    sum;

  assign s1_valid = (occ_q == S1_ONLY) || (occ_q == FULL);
  assign s2_valid = (occ_q == S2_ONLY) || (occ_q == FULL);

  // Grants are suppressed in the reset cycle so req_ready reads 0 there.
  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_arb (
    .req (bus.req_valid),
    .ptr (rr_ptr),
    .en  (s1_acc && !rst),
    .gnt (gnt),
    .idx (win)
  );

  Adder_gear #(
    .R       (R),
    .P       (P),
    .WIDTH_A (WIDTH_A),
    .WIDTH_B (WIDTH_B)
  ) u_adder (
    .A   (s1_a),
    .B   (s1_b),
    .Cin (s1_carry),
    .OUT (sum)
  );

  always_ff @(posedge clk) begin
    if (rst) occ_q <= EMPTY;
    else     occ_q <= occ_d;
  end

  always_comb begin
    s2_adv  = !s2_valid || bus.res_ready;
    s1_acc  = !s1_valid || s2_adv;
    hs      = |(bus.req_valid & gnt);
    s1_next = s1_acc ? hs : s1_valid;
    s2_next = s2_adv ? s1_valid : s2_valid;
    occ_d   = EMPTY;
    case ({s1_next, s2_next})
      2'b01:   occ_d = S2_ONLY;
      2'b10:   occ_d = S1_ONLY;
      2'b11:   occ_d = FULL;
      default: occ_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_a     <= '0;
      s1_b     <= '0;
      s1_carry <= 1'b0;
      s1_id    <= '0;
      s2_data  <= '0;
      s2_id    <= '0;
      rr_ptr   <= '0;
    end else begin
      if (s2_adv && s1_valid) begin
        s2_data <= sum;
        s2_id   <= s1_id;
      end
      if (hs) begin
        s1_a     <= bus.req_a[win*WIDTH_A +: WIDTH_A];
        s1_b     <= bus.req_b[win*WIDTH_B +: WIDTH_B];
        s1_carry <= bus.req_carry[win];
        s1_id    <= win;
        rr_ptr   <= (win == LAST) ? '0 : win + 1'b1;
      end
    end
  end

  assign bus.req_ready = gnt;
  assign bus.res_valid = s2_valid;
  assign bus.res_data  = s2_data;
  assign bus.res_id    = s2_id;
  assign bus.busy      = (occ_q != EMPTY);

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed bench for adder_share_arb (NUM_REQ=4, WIDTH_A=4, WIDTH_B=8, R=0, P=2).
// Inputs change 1 ns after the rising edge; outputs are checked 1-2 ns after it.
module tb_adder_share_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  adder_share_arb_if #(
    .NUM_REQ (4),
    .WIDTH_A (4),
    .WIDTH_B (8)
  ) bus ();

  adder_share_arb #(
    .NUM_REQ (4),
    .WIDTH_A (4),
    .WIDTH_B (8),
    .R       (0),
    .P       (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] a,
                         input logic [7:0] b, input logic c);
    bus.req_valid[i]     = v;
    bus.req_a[i*4 +: 4]  = a;
    bus.req_b[i*8 +: 8]  = b;
    bus.req_carry[i]     = c;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 4'hF;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_carry = '0;
    bus.res_ready = 1'b1;

    // Reset held two cycles with every requester valid.
    tick();
    chk("rst_res_valid", 32'(bus.res_valid), 32'h0);
    chk("rst_busy",      32'(bus.busy),      32'h0);
    chk("rst_res_data",  32'(bus.res_data),  32'h0);
    chk("rst_res_id",    32'(bus.res_id),    32'h0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    tick();
    chk("rst_req_ready2", 32'(bus.req_ready), 32'h0);
    rst = 1'b0;
    #1;
    chk("first_grant", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    tick();

    // Single op from requester 2 (pointer is at 1).
    set_req(2, 1'b1, 4'd4, 8'd3, 1'b0);
    #1;
    chk("single_ready", 32'(bus.req_ready), 32'h4);
    tick();
    set_req(2, 1'b0, 4'd4, 8'd3, 1'b0);
    chk("single_t1_valid", 32'(bus.res_valid), 32'h0);
    chk("single_t1_busy",  32'(bus.busy),      32'h1);
    tick();
    chk("single_t2_valid", 32'(bus.res_valid), 32'h1);
    chk("single_data",     32'(bus.res_data),  32'h7);
    chk("single_id",       32'(bus.res_id),    32'h2);
    tick();
    chk("single_t3_valid", 32'(bus.res_valid), 32'h0);

    // Pointer is 3; only requester 1 valid, so the search wraps 3->0->1.
    set_req(1, 1'b1, 4'd1, 8'd1, 1'b0);
    #1;
    chk("wrap_ready", 32'(bus.req_ready), 32'h2);
    tick();
    set_req(1, 1'b0, 4'd1, 8'd1, 1'b0);
    rst = 1'b1;
    tick();
    chk("midrst_valid", 32'(bus.res_valid), 32'h0);
    chk("midrst_busy",  32'(bus.busy),      32'h0);
    rst = 1'b0;
    tick();
    chk("midrst_valid2", 32'(bus.res_valid), 32'h0);
    tick();
    chk("midrst_valid3", 32'(bus.res_valid), 32'h0);

    // Fairness: everyone valid, result data = 0x20 + id.
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 4'(i), 8'h20, 1'b0);
    #1;
    chk("ptr_after_rst", 32'(bus.req_ready), 32'h1);
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("fair%0d_valid", k), 32'(bus.res_valid), 32'h1);
      chk($sformatf("fair%0d_id", k),    32'(bus.res_id),    32'(k % 4));
      chk($sformatf("fair%0d_data", k),  32'(bus.res_data),  32'(8'h20 + k % 4));
    end
    bus.req_valid = '0;
    tick();
    tick();

    // Backpressure: fill S1 and S2, then stall with requester 0 waiting.
    bus.res_ready = 1'b0;
    set_req(2, 1'b1, 4'd1, 8'd2, 1'b0);
    #1;
    chk("bp_ready0", 32'(bus.req_ready), 32'h4);
    tick();
    set_req(2, 1'b0, 4'd1, 8'd2, 1'b0);
    set_req(3, 1'b1, 4'd8, 8'd1, 1'b0);
    #1;
    chk("bp_ready1", 32'(bus.req_ready), 32'h8);
    tick();
    set_req(3, 1'b0, 4'd8, 8'd1, 1'b0);
    set_req(0, 1'b1, 4'd2, 8'd2, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("stall%0d_ready", k), 32'(bus.req_ready), 32'h0);
      chk($sformatf("stall%0d_valid", k), 32'(bus.res_valid), 32'h1);
      chk($sformatf("stall%0d_data", k),  32'(bus.res_data),  32'h3);
      chk($sformatf("stall%0d_id", k),    32'(bus.res_id),    32'h2);
      tick();
    end
    bus.res_ready = 1'b1;
    #1;
    chk("full_accept_ready", 32'(bus.req_ready), 32'h1);
    tick();
    set_req(0, 1'b0, 4'd2, 8'd2, 1'b0);
    chk("bp_second_valid", 32'(bus.res_valid), 32'h1);
    chk("bp_second_data",  32'(bus.res_data),  32'h9);
    chk("bp_second_id",    32'(bus.res_id),    32'h3);
    tick();
    chk("bp_third_valid", 32'(bus.res_valid), 32'h1);
    chk("bp_third_data",  32'(bus.res_data),  32'h4);
    chk("bp_third_id",    32'(bus.res_id),    32'h0);
    tick();
    chk("bp_drain_valid", 32'(bus.res_valid), 32'h0);
    chk("bp_drain_busy",  32'(bus.busy),      32'h0);

    // Carry-in with A = -1: the upper-segment carry is predicted as 0 -> 0x01.
    set_req(1, 1'b1, 4'hF, 8'h01, 1'b1);
    #1;
    chk("carry_ready", 32'(bus.req_ready), 32'h2);
    tick();
    set_req(1, 1'b0, 4'hF, 8'h01, 1'b1);
    tick();
    chk("carry_valid", 32'(bus.res_valid), 32'h1);
    chk("carry_data",  32'(bus.res_data),  32'h01);
    chk("carry_id",    32'(bus.res_id),    32'h1);
    tick();

    // 0x07 + 0x7F + 1: segment carries predicted 1,1,0 -> 0x47 (exact 0x87).
    set_req(3, 1'b1, 4'h7, 8'h7F, 1'b1);
    #1;
    chk("approx_ready", 32'(bus.req_ready), 32'h8);
    tick();
    set_req(3, 1'b0, 4'h7, 8'h7F, 1'b1);
    tick();
    chk("approx_valid", 32'(bus.res_valid), 32'h1);
    chk("approx_data",  32'(bus.res_data),  32'h47);
    chk("approx_id",    32'(bus.res_id),    32'h3);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
